// File: rtl/tim_ctrl_if.sv
// Peripheral bus bundle for tim_ctrl: one-cycle request strobe answered by a
// registered ready pulse carrying the read data.
interface tim_ctrl_if;
  logic        sel;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, we, addr, wdata, input rdata, ready);
  modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/tim_ctrl.sv
// Bus-mapped controller for one tim timer: preload/shadow registers, stop/load/run
// sequencing through tim_rst, and update-event flag, counter and interrupt.
module tim_ctrl (
  input  logic        clk,
  input  logic        rst,
  tim_ctrl_if.slave   bus,
  output logic        irq,
  output logic        tim_rst,
  output logic [15:0] tim_prescaler,
  output logic [15:0] tim_period,
  output logic [15:0] tim_pulse,
  input  logic        tim_update
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        en_r, opm_r, ie_r, arpe_r, uif_r, upd_q_r;
  logic        ready_r, irq_r, tim_rst_r;
  logic [31:0] rdata_r;
  logic [15:0] psc_r, arr_r, ccr_r, cnt_r;
  logic [15:0] sh_psc_r, sh_arr_r, sh_ccr_r;

  logic [2:0]  idx_s;
  logic        wr_s, run_s, evt_s, reload_s;
  logic        wr_ctrl_s, wr_psc_s, wr_arr_s, wr_ccr_s, wr_sr_s, wr_cnt_s;
  logic        en_nxt_s, ie_nxt_s, uif_nxt_s;
  logic [15:0] cnt_nxt_s;
  logic [31:0] rd_mux_s;

  assign idx_s = bus.addr[4:2];

  // Write decode and update-event detection (rising edge of tim_update while running)
  always_comb begin
    wr_s      = bus.sel & bus.we;
    wr_ctrl_s = wr_s & (idx_s == 3'd0);
    wr_psc_s  = wr_s & (idx_s == 3'd1);
    wr_arr_s  = wr_s & (idx_s == 3'd2);
    wr_ccr_s  = wr_s & (idx_s == 3'd3);
    wr_sr_s   = wr_s & (idx_s == 3'd4);
    wr_cnt_s  = wr_s & (idx_s == 3'd5);
    run_s     = (state_r == ST_RUN);
    evt_s     = run_s & tim_update & ~upd_q_r;
    reload_s  = (state_r == ST_LOAD) | (evt_s & arpe_r);
  end

  // Read mux over pre-write register values
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      3'd0:    rd_mux_s = {28'd0, arpe_r, ie_r, opm_r, en_r};
      3'd1:    rd_mux_s = {16'd0, psc_r};
      3'd2:    rd_mux_s = {16'd0, arr_r};
      3'd3:    rd_mux_s = {16'd0, ccr_r};
      3'd4:    rd_mux_s = {31'd0, uif_r};
      3'd5:    rd_mux_s = {16'd0, cnt_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Next-state logic for the stop/load/run sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_r) state_nxt_s = ST_LOAD;
        else      state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (!en_r || (evt_s && opm_r)) state_nxt_s = ST_IDLE;
        else                           state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of software-visible status; hardware set beats W1C, event after CNT clear
  always_comb begin
    en_nxt_s  = wr_ctrl_s ? bus.wdata[0] : ((evt_s & opm_r) ? 1'b0 : en_r);
    ie_nxt_s  = wr_ctrl_s ? bus.wdata[2] : ie_r;
    uif_nxt_s = (uif_r & ~(wr_sr_s & bus.wdata[0])) | evt_s;
    cnt_nxt_s = (wr_cnt_s ? 16'd0 : cnt_r) + {15'd0, evt_s};
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Control, preload, status and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r <= 1'b0; opm_r <= 1'b0; ie_r <= 1'b0; arpe_r <= 1'b0;
      psc_r <= 16'd0; arr_r <= 16'd0; ccr_r <= 16'd0;
      uif_r <= 1'b0; cnt_r <= 16'd0; upd_q_r <= 1'b0;
    end else begin
      en_r    <= en_nxt_s;
      ie_r    <= ie_nxt_s;
      opm_r   <= wr_ctrl_s ? bus.wdata[1] : opm_r;
      arpe_r  <= wr_ctrl_s ? bus.wdata[3] : arpe_r;
      psc_r   <= wr_psc_s ? bus.wdata[15:0] : psc_r;
      arr_r   <= wr_arr_s ? bus.wdata[15:0] : arr_r;
      ccr_r   <= wr_ccr_s ? bus.wdata[15:0] : ccr_r;
      uif_r   <= uif_nxt_s;
      cnt_r   <= cnt_nxt_s;
      upd_q_r <= run_s ? tim_update : 1'b0;
    end
  end

  // Shadows: bulk load on LOAD or buffered reload; direct write-through when unbuffered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_psc_r <= 16'd0; sh_arr_r <= 16'd0; sh_ccr_r <= 16'd0;
    end else if (reload_s) begin
      sh_psc_r <= psc_r; sh_arr_r <= arr_r; sh_ccr_r <= ccr_r;
    end else begin
      sh_psc_r <= (run_s & ~arpe_r & wr_psc_s) ? bus.wdata[15:0] : sh_psc_r;
      sh_arr_r <= (run_s & ~arpe_r & wr_arr_s) ? bus.wdata[15:0] : sh_arr_r;
      sh_ccr_r <= (run_s & ~arpe_r & wr_ccr_s) ? bus.wdata[15:0] : sh_ccr_r;
    end
  end

  // Registered bus reply, interrupt level and timer reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r <= 1'b0; rdata_r <= 32'd0; irq_r <= 1'b0; tim_rst_r <= 1'b1;
    end else begin
      ready_r   <= bus.sel;
      rdata_r   <= (bus.sel & ~bus.we) ? rd_mux_s : 32'd0;
      irq_r     <= uif_nxt_s & ie_nxt_s;
      tim_rst_r <= (state_nxt_s != ST_RUN);
    end
  end

  assign bus.ready     = ready_r;
  assign bus.rdata     = rdata_r;
  assign irq           = irq_r;
  assign tim_rst       = tim_rst_r;
  assign tim_prescaler = sh_psc_r;
  assign tim_period    = sh_arr_r;
  assign tim_pulse     = sh_ccr_r;

endmodule

// File: tb/tb_tim_ctrl.sv
// Directed plus random bench for tim_ctrl with a rule-level reference model and a
// stand-in tim timer (prescaled counter, update level while count equals period).
module tb_tim_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        irq, tim_rst, tim_update;
  logic [15:0] tim_prescaler, tim_period, tim_pulse;

  tim_ctrl_if bus ();

  tim_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .irq(irq), .tim_rst(tim_rst),
    .tim_prescaler(tim_prescaler), .tim_period(tim_period), .tim_pulse(tim_pulse),
    .tim_update(tim_update)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register file, run phase (0 stopped, 1 loading, 2 running)
  logic        m_en, m_opm, m_ie, m_arpe, m_uif, m_prev, m_ready;
  logic [15:0] m_psc, m_arr, m_ccr, m_cnt, m_sp, m_sa, m_sc;
  logic [31:0] m_rdata;
  int          m_phase;
  logic [15:0] t_cnt, t_pre;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] i);
    case (i)
      3'd0:    m_read = {28'd0, m_arpe, m_ie, m_opm, m_en};
      3'd1:    m_read = {16'd0, m_psc};
      3'd2:    m_read = {16'd0, m_arr};
      3'd3:    m_read = {16'd0, m_ccr};
      3'd4:    m_read = {31'd0, m_uif};
      3'd5:    m_read = {16'd0, m_cnt};
      default: m_read = 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    {m_en, m_opm, m_ie, m_arpe, m_uif, m_prev, m_ready} = 7'd0;
    {m_psc, m_arr, m_ccr, m_cnt, m_sp, m_sa, m_sc} = '0;
    m_rdata = 32'd0; m_phase = 0; t_cnt = 16'd0; t_pre = 16'd0;
    tim_update = (t_cnt == m_sa);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rdata"}, bus.rdata, m_rdata);
    chk({tag, ".ready"}, {31'd0, bus.ready}, {31'd0, m_ready});
    chk({tag, ".irq"}, {31'd0, irq}, {31'd0, m_uif & m_ie});
    chk({tag, ".tim_rst"}, {31'd0, tim_rst}, {31'd0, (m_phase != 2)});
    chk({tag, ".psc"}, {16'd0, tim_prescaler}, {16'd0, m_sp});
    chk({tag, ".period"}, {16'd0, tim_period}, {16'd0, m_sa});
    chk({tag, ".pulse"}, {16'd0, tim_pulse}, {16'd0, m_sc});
  endtask

  // One clock: present a bus op, advance model and stand-in timer, compare
  task automatic step(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
    logic       tu, evt, o_en, o_opm, o_arpe, wr;
    logic [2:0] i;
    logic [15:0] o_psc, o_arr, o_ccr;
    int         o_phase;
    bus.sel = s; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    i = a[4:2]; wr = s & w; tu = tim_update;
    o_en = m_en; o_opm = m_opm; o_arpe = m_arpe; o_phase = m_phase;
    o_psc = m_psc; o_arr = m_arr; o_ccr = m_ccr;
    evt = (o_phase == 2) && tu && !m_prev;
    m_ready = s;
    m_rdata = (s && !w) ? m_read(i) : 32'd0;
    if (o_phase != 2) begin
      t_cnt = 16'd0; t_pre = 16'd0;
    end else if (t_pre >= m_sp) begin
      t_pre = 16'd0; t_cnt = (t_cnt >= m_sa) ? 16'd0 : t_cnt + 16'd1;
    end else begin
      t_pre = t_pre + 16'd1;
    end
    if (wr) begin
      case (i)
        3'd0: {m_arpe, m_ie, m_opm, m_en} = d[3:0];
        3'd1: m_psc = d[15:0];
        3'd2: m_arr = d[15:0];
        3'd3: m_ccr = d[15:0];
        3'd4: if (d[0]) m_uif = 1'b0;
        3'd5: m_cnt = 16'd0;
        default: ;
      endcase
    end
    if (o_phase == 1 || (evt && o_arpe)) begin
      m_sp = o_psc; m_sa = o_arr; m_sc = o_ccr;
    end else if (o_phase == 2 && !o_arpe && wr) begin
      if (i == 3'd1) m_sp = d[15:0];
      if (i == 3'd2) m_sa = d[15:0];
      if (i == 3'd3) m_sc = d[15:0];
    end
    if (evt) begin
      m_uif = 1'b1;
      m_cnt = m_cnt + 16'd1;
      if (o_opm && !(wr && i == 3'd0)) m_en = 1'b0;
    end
    m_prev = (o_phase == 2) ? tu : 1'b0;
    case (o_phase)
      0:       m_phase = o_en ? 1 : 0;
      1:       m_phase = 2;
      default: m_phase = (!o_en || (evt && o_opm)) ? 0 : 2;
    endcase
    tim_update = (t_cnt == m_sa);
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [2:0] i, input logic [31:0] d);
    step(1'b1, 1'b1, {i, 2'b00}, d);
  endtask

  task automatic rd_reg(input logic [2:0] i);
    step(1'b1, 1'b0, {i, 2'b00}, 32'd0);
  endtask

  // Idle until the next clock edge will register an update event, bounded
  task automatic wait_evt();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (m_phase == 2 && tim_update && !m_prev) ok = 1'b1;
      else idle(1);
    end
    chk("wait_evt", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 5'd0; bus.wdata = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd_reg(i[2:0]);
      chk("reset_read", bus.rdata, 32'd0);
    end

    // Continuous run: PSC=1, ARR=3, EN|IE
    wr_reg(3'd1, 32'd1);
    wr_reg(3'd2, 32'd3);
    wr_reg(3'd0, 32'h5);
    idle(1);
    chk("start_lat1", {31'd0, tim_rst}, 32'd1);
    idle(1);
    chk("start_lat2", {31'd0, tim_rst}, 32'd0);
    idle(24);
    rd_reg(3'd5);
    chk("cnt_after3", bus.rdata, 32'd3);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr_reg(3'd4, 32'd1);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    wr_reg(3'd0, 32'h0);
    idle(2);

    // One-pulse run
    wr_reg(3'd5, 32'd0);
    wr_reg(3'd2, 32'd4);
    wr_reg(3'd0, 32'h3);
    idle(40);
    rd_reg(3'd0);
    chk("opm_ctrl", bus.rdata, 32'h2);
    chk("opm_timrst", {31'd0, tim_rst}, 32'd1);
    rd_reg(3'd5);
    chk("opm_cnt", bus.rdata, 32'd1);

    // Buffered reload, then unbuffered write-through
    wr_reg(3'd4, 32'd1);
    wr_reg(3'd2, 32'd5);
    wr_reg(3'd0, 32'h9);
    idle(6);
    wr_reg(3'd2, 32'd2);
    chk("arpe_hold", {16'd0, tim_period}, 32'd5);
    wait_evt();
    idle(1);
    chk("arpe_reload", {16'd0, tim_period}, 32'd2);
    wr_reg(3'd0, 32'h1);
    wr_reg(3'd2, 32'd5);
    chk("direct_5", {16'd0, tim_period}, 32'd5);
    idle(3);
    wr_reg(3'd2, 32'd2);
    chk("direct_2", {16'd0, tim_period}, 32'd2);

    // Event coinciding with W1C, then with a CNT clear
    wait_evt();
    wr_reg(3'd4, 32'd1);
    rd_reg(3'd4);
    chk("w1c_vs_set", bus.rdata, 32'd1);
    wait_evt();
    wr_reg(3'd5, 32'd0);
    rd_reg(3'd5);
    chk("cnt_vs_evt", bus.rdata, 32'd1);

    // Asynchronous reset while running
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b1;
    idle(30);
    rd_reg(3'd5);
    chk("post_rst_cnt", bus.rdata, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [2:0]  i;
      logic [31:0] d;
      i = 3'($urandom_range(0, 7));
      d = $urandom;
      case (i)
        3'd0: d[0] = ($urandom_range(0, 3) != 0);
        3'd1: d = 32'($urandom_range(0, 2));
        3'd2: d = 32'($urandom_range(0, 9));
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) step(1'b1, 1'($urandom_range(0, 1)), {i, 2'b00}, d);
      else idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
